// File: rtl/laa_matmul_responder.sv
// rtl/laa_matmul_responder.sv - LAA bus responder: 32-entry register file with a sequential 2x2 matrix multiply
// Register 31 is a read-only STATUS word that the core polls for multiply completion.
module laa_matmul_responder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        opcode,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;
  localparam logic [4:0] STATUS_ADDR = 5'd31;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [1:0]        prev_op_q, prev_op_d;

  logic              start;
  logic              last_mac;
  logic [4:0]        a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] prod;

  // A start needs a rising MULTIPLY edge so a held opcode runs only once.
  always_comb begin
    start    = (opcode == OP_MUL) && (prev_op_q != OP_MUL) && (state_q == S_IDLE);
    last_mac = (state_q == S_CALC) && (cnt_q == 3'd7);
    // cnt = {i, j, k}: A[i][k] at 2i+k, B[k][j] at 4+2k+j, C[i][j] at 8+2i+j
    a_idx    = {3'b000, cnt_q[2], cnt_q[0]};
    b_idx    = {3'b001, cnt_q[0], cnt_q[1]};
    c_idx    = {3'b010, cnt_q[2], cnt_q[1]};
    prod     = regs_q[a_idx] * regs_q[b_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      prev_op_q <= OP_NONE;
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      prev_op_q <= prev_op_d;
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last_mac) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    regs_d    = regs_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    prev_op_d = opcode;
    if (state_q == S_IDLE) begin
      if (opcode == OP_WRITE && addr != STATUS_ADDR) begin
        regs_d[addr] = data_in;
      end
      if (start) begin
        cnt_d               = '0;
        acc_d               = '0;
        regs_d[STATUS_ADDR] = '0;
      end
    end else begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q[0] == 1'b0) begin
        acc_d = prod;
      end else begin
        regs_d[c_idx] = acc_q + prod;
      end
      if (last_mac) begin
        regs_d[STATUS_ADDR] = {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    busy     = (state_q == S_CALC);
    data_out = (opcode == OP_READ) ? regs_q[addr] : '0;
  end

endmodule

// File: tb/tb_laa_matmul_responder.sv
// tb/tb_laa_matmul_responder.sv - directed plus randomized checks of laa_matmul_responder against a matrix-level model
module tb_laa_matmul_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  opcode;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_regs [32];

  laa_matmul_responder #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit upd);
    opcode = 2'd2; addr = a; data_in = d;
    tick();
    opcode = 2'd0;
    if (upd && a != 5'd31) m_regs[a] = d;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    opcode = 2'd1; addr = a;
    #2;
    check(tag, data_out, exp);
    tick();
    opcode = 2'd0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
  endtask

  // C = A x B over 2x2 matrices, each product and sum truncated to 32 bits.
  task automatic model_mul();
    logic [31:0] a [2][2];
    logic [31:0] b [2][2];
    logic [31:0] p0, p1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        a[i][k] = m_regs[2*i+k];
        b[i][k] = m_regs[4+2*i+k];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        p0 = a[i][0] * b[0][j];
        p1 = a[i][1] * b[1][j];
        m_regs[8+2*i+j] = p0 + p1;
      end
    m_regs[31] = 32'd1;
  endtask

  task automatic check_c(input string tag);
    for (int r = 8; r < 12; r++) chk_reg($sformatf("%s_c%0d", tag, r), r[4:0], m_regs[r]);
  endtask

  // Pulse MULTIPLY one cycle, then watch busy and STATUS through all 8 CALC cycles.
  task automatic do_mul(input string tag);
    opcode = 2'd3;
    tick();
    for (int c = 0; c < 8; c++) begin
      opcode = 2'd1; addr = 5'd31;
      #1;
      check($sformatf("%s_busy%0d", tag, c), {31'd0, busy}, 32'd1);
      check($sformatf("%s_stat%0d", tag, c), data_out, 32'd0);
      tick();
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk_reg({tag, "_done"}, 5'd31, 32'd1);
    model_mul();
    check_c(tag);
  endtask

  task automatic load_ab(input logic [31:0] v [8]);
    for (int r = 0; r < 8; r++) wr(r[4:0], v[r], 1'b1);
  endtask

  initial begin
    logic [31:0] v [8];
    logic [4:0]  ra;
    logic [31:0] rd;
    int          n;

    rst = 1'b1; opcode = 2'd0; addr = '0; data_in = '0;
    tick(); tick();
    rst = 1'b0;
    model_reset();

    check("rst_busy", {31'd0, busy}, 32'd0);
    chk_reg("rst_status", 5'd31, 32'd0);

    wr(5'd5, 32'hDEADBEEF, 1'b1);
    chk_reg("wr5", 5'd5, 32'hDEADBEEF);
    opcode = 2'd0; addr = 5'd5;
    #2;
    check("none_out", data_out, 32'd0);
    tick();
    wr(5'd31, 32'h1234, 1'b1);
    chk_reg("wr31_ignored", 5'd31, 32'd0);

    v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    load_ab(v);
    do_mul("mul");
    chk_reg("mul_c00_const", 5'd8, 32'd19);
    chk_reg("mul_c11_const", 5'd11, 32'd50);

    v = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0};
    load_ab(v);
    do_mul("wrap");
    chk_reg("wrap_c00_const", 5'd8, 32'hFFFFFFFE);

    // Writes during CALC must be dropped; reads must still work.
    v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    load_ab(v);
    opcode = 2'd3;
    tick();
    wr(5'd0, 32'd100, 1'b0);
    wr(5'd8, 32'd7, 1'b0);
    opcode = 2'd1; addr = 5'd4;
    #2;
    check("blk_read4", data_out, 32'd5);
    tick();
    opcode = 2'd0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("blk_done", {31'd0, busy}, 32'd0);
    model_mul();
    chk_reg("blk_reg0", 5'd0, 32'd1);
    chk_reg("blk_reg8", 5'd8, 32'd19);
    chk_reg("blk_status", 5'd31, 32'd1);

    for (int t = 0; t < 5; t++) begin
      for (int r = 0; r < 8; r++)
        v[r] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 15));
      load_ab(v);
      do_mul($sformatf("rnd%0d", t));
    end

    // Held MULTIPLY starts exactly one run.
    opcode = 2'd3;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("hold_busy%0d", k), {31'd0, busy}, (k <= 8) ? 32'd1 : 32'd0);
    end
    chk_reg("hold_status", 5'd31, 32'd1);
    do_mul("rehit");

    opcode = 2'd3;
    tick();
    opcode = 2'd0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int r = 0; r < 32; r++) chk_reg($sformatf("midrst_r%0d", r), r[4:0], 32'd0);
    wr(5'd12, 32'hCAFEF00D, 1'b1);
    chk_reg("midrst_wr12", 5'd12, 32'hCAFEF00D);

    for (int t = 0; t < 12; t++) begin
      ra = 5'($urandom_range(12, 31));
      rd = $urandom();
      wr(ra, rd, 1'b1);
    end
    for (int r = 12; r < 32; r++) chk_reg($sformatf("scr_r%0d", r), r[4:0], m_regs[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
